// File: rtl/alu_mem_bus_master.sv
// Command sequencer for the ALU/memory slave: writes A, B and opcode, polls status
// until done (or a poll budget runs out), then holds a response until it is taken.
module alu_mem_bus_master #(
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int RES_WIDTH   = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int MAX_POLL    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [DATA_WIDTH-1:0] cmd_op,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_wr,
  output logic                  enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [RES_WIDTH-1:0]  res_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_result,
  output logic [DATA_WIDTH-1:0] rsp_status
);

  // state  | meaning
  // IDLE   | ready for a request
  // WR_A   | write operand A to reg 0
  // WR_B   | write operand B to reg 1
  // WR_OP  | write opcode to reg 2 (starts the slave)
  // WAIT   | idle gap before the first status read
  // RD_ST  | read strobe on status reg 3
  // SAMPLE | rd_data valid; decide done / repoll / timeout
  // RESP   | response held until rsp_ready
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, WAIT, RD_ST, SAMPLE, RESP} state_t;

  localparam int PW = $clog2(MAX_POLL + 1);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] b_q, b_d, op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_wr_q, rd_wr_d;
  logic [3:0]            wait_q, wait_d;
  logic [PW-1:0]         poll_q, poll_d;
  logic [RES_WIDTH-1:0]  result_q, result_d;
  logic [DATA_WIDTH-1:0] status_q, status_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      b_q       <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_wr_q   <= 1'b0;
      wait_q    <= '0;
      poll_q    <= '0;
      result_q  <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_wr_q   <= rd_wr_d;
      wait_q    <= wait_d;
      poll_q    <= poll_d;
      result_q  <= result_d;
      status_q  <= status_d;
    end
  end

  // Bus address/data are loaded on entry to each access state so they hold when idle.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_wr_d   = rd_wr_q;
    wait_d    = wait_q;
    poll_d    = poll_q;
    result_d  = result_q;
    status_d  = status_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d   = WR_A;
          b_d       = cmd_b;
          op_d      = cmd_op;
          addr_d    = ADDR_WIDTH'(0);
          wr_data_d = cmd_a;
          rd_wr_d   = 1'b0;
          poll_d    = '0;
        end
      end
      WR_A: begin
        state_d   = WR_B;
        addr_d    = ADDR_WIDTH'(1);
        wr_data_d = b_q;
      end
      WR_B: begin
        state_d   = WR_OP;
        addr_d    = ADDR_WIDTH'(2);
        wr_data_d = op_q;
      end
      WR_OP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = RD_ST;
          addr_d  = ADDR_WIDTH'(3);
          rd_wr_d = 1'b1;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          state_d = RD_ST;
          addr_d  = ADDR_WIDTH'(3);
          rd_wr_d = 1'b1;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RD_ST: begin
        state_d = SAMPLE;
        poll_d  = poll_q + PW'(1);
      end
      SAMPLE: begin
        status_d = rd_data;
        if (rd_data[0]) begin
          result_d = res_out;
          state_d  = RESP;
        end else if (poll_q < PW'(MAX_POLL)) begin
          state_d = RD_ST;
        end else begin
          status_d[7] = 1'b1;
          result_d    = '0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == IDLE);
  assign enable     = (state_q == WR_A) || (state_q == WR_B) || (state_q == WR_OP) ||
                      (state_q == RD_ST);
  assign rsp_valid  = (state_q == RESP);
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign rd_wr      = rd_wr_q;
  assign rsp_result = result_q;
  assign rsp_status = status_q;

endmodule

// File: tb/tb_alu_mem_bus_master.sv
// Bench for alu_mem_bus_master: a reactive slave model logs bus traffic and supplies
// status reads; each test compares against expectations derived from the command rules.
module tb_alu_mem_bus_master;
  localparam int AW = 2, DW = 8, RW = 16, WAIT_CYCLES = 2, MAX_POLL = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0, cmd_op = '0;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic          rd_wr, enable;
  logic [DW-1:0] rd_data = '0;
  logic [RW-1:0] res_out = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [RW-1:0] rsp_result;
  logic [DW-1:0] rsp_status;

  int tests_run = 0, tests_failed = 0;

  // slave behaviour knobs: done appears on read number done_on (0 = never)
  int            done_on = 1;
  logic [DW-1:0] done_st = 8'h01, nd_st = 8'h00;

  // traffic log, written only by the slave process
  logic [AW-1:0] wlog_addr [0:255];
  logic [DW-1:0] wlog_data [0:255];
  int wn = 0, rn_total = 0, rn_bad = 0, rd_count = 0;

  alu_mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RES_WIDTH(RW),
                       .WAIT_CYCLES(WAIT_CYCLES), .MAX_POLL(MAX_POLL)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .addr(addr), .wr_data(wr_data),
    .rd_wr(rd_wr), .enable(enable), .rd_data(rd_data), .res_out(res_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_status(rsp_status));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (enable === 1'b1 && rd_wr === 1'b0) begin
      wlog_addr[wn & 255] <= addr;
      wlog_data[wn & 255] <= wr_data;
      wn <= wn + 1;
      if (addr == 2'd2) rd_count <= 0;
    end
    if (enable === 1'b1 && rd_wr === 1'b1) begin
      rn_total <= rn_total + 1;
      if (addr != 2'd3) rn_bad <= rn_bad + 1;
      rd_count <= rd_count + 1;
      rd_data  <= (rd_count + 1 == done_on) ? done_st : nd_st;
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] op);
    int n = 0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL issue_ready_timeout: cmd_ready=%b, required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = DW'($urandom); cmd_b = DW'($urandom); cmd_op = DW'($urandom);
  endtask

  // cycles from the first cycle after accept until rsp_valid is seen
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 300) begin lat++; @(negedge clk); end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (enable !== 1'b0 || rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold: enable=%b rsp_valid=%b, required 0 0", enable, rsp_valid);
      end
    end
    cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cmd_ready !== 1'b1 || addr !== 2'd0 || wr_data !== 8'd0 || rd_wr !== 1'b0 ||
        rsp_result !== 16'd0 || rsp_status !== 8'd0 || wn != 0) begin
      tests_failed++;
      $display("FAIL reset_state: rdy=%b addr=%h wd=%h rw=%b res=%h st=%h writes=%0d, required 1 0 00 0 0000 00 0",
               cmd_ready, addr, wr_data, rd_wr, rsp_result, rsp_status, wn);
    end
  endtask

  task automatic test_single_op();
    int lat, w0, r0;
    done_on = 1; done_st = 8'h01; nd_st = 8'h00; res_out = 16'h0046;
    w0 = wn; r0 = rn_total;
    issue(8'h12, 8'h34, 8'h01);
    wait_rsp(lat);
    tests_run++;
    if (lat != 7) begin tests_failed++; $display("FAIL single_latency: got %0d, required 7", lat); end
    tests_run++;
    if (wn - w0 != 3 || wlog_addr[w0 & 255] !== 2'd0 || wlog_data[w0 & 255] !== 8'h12 ||
        wlog_addr[(w0 + 1) & 255] !== 2'd1 || wlog_data[(w0 + 1) & 255] !== 8'h34 ||
        wlog_addr[(w0 + 2) & 255] !== 2'd2 || wlog_data[(w0 + 2) & 255] !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_writes: n=%0d %h@%0d %h@%0d %h@%0d, required 3 12@0 34@1 01@2", wn - w0,
               wlog_data[w0 & 255], wlog_addr[w0 & 255], wlog_data[(w0 + 1) & 255],
               wlog_addr[(w0 + 1) & 255], wlog_data[(w0 + 2) & 255], wlog_addr[(w0 + 2) & 255]);
    end
    tests_run++;
    if (rn_total - r0 != 1 || rn_bad != 0) begin
      tests_failed++;
      $display("FAIL single_reads: got %0d (bad addr %0d), required 1 (0)", rn_total - r0, rn_bad);
    end
    tests_run++;
    if (rsp_result !== 16'h0046 || rsp_status !== 8'h01) begin
      tests_failed++;
      $display("FAIL single_rsp: result=%h status=%h, required 0046 01", rsp_result, rsp_status);
    end
    release_rsp();
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_release: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_slow_slave();
    int lat, r0;
    done_on = 3; done_st = 8'h01; nd_st = 8'h00; res_out = 16'h0046;
    r0 = rn_total;
    issue(8'h12, 8'h34, 8'h01);
    wait_rsp(lat);
    tests_run++;
    if (rn_total - r0 != 3 || rn_bad != 0 || lat != 11) begin
      tests_failed++;
      $display("FAIL slow_reads: reads=%0d bad=%0d lat=%0d, required 3 0 11", rn_total - r0, rn_bad, lat);
    end
    tests_run++;
    if (rsp_result !== 16'h0046 || rsp_status !== 8'h01) begin
      tests_failed++;
      $display("FAIL slow_rsp: result=%h status=%h, required 0046 01", rsp_result, rsp_status);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    int lat, r0;
    done_on = 0; nd_st = 8'h00; res_out = 16'hBEEF;
    r0 = rn_total;
    issue(8'h55, 8'hAA, 8'h03);
    wait_rsp(lat);
    tests_run++;
    if (rn_total - r0 != MAX_POLL || lat != 3 + WAIT_CYCLES + 2 * MAX_POLL) begin
      tests_failed++;
      $display("FAIL timeout_reads: reads=%0d lat=%0d, required %0d %0d", rn_total - r0, lat,
               MAX_POLL, 3 + WAIT_CYCLES + 2 * MAX_POLL);
    end
    tests_run++;
    if (rsp_status !== 8'h80 || rsp_result !== 16'h0000) begin
      tests_failed++;
      $display("FAIL timeout_rsp: status=%h result=%h, required 80 0000", rsp_status, rsp_result);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int lat, w0, r0;
    done_on = 1; done_st = 8'h05; res_out = 16'h1234;
    issue(8'h01, 8'h02, 8'h07);
    wait_rsp(lat);
    w0 = wn; r0 = rn_total;
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'h1234 || rsp_status !== 8'h05 ||
          cmd_ready !== 1'b0 || enable !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold: valid=%b res=%h st=%h rdy=%b en=%b, required 1 1234 05 0 0",
                 rsp_valid, rsp_result, rsp_status, cmd_ready, enable);
      end
    end
    tests_run++;
    if (wn != w0 || rn_total != r0) begin
      tests_failed++;
      $display("FAIL bp_strobes: %0d accesses during hold, required 0", (wn - w0) + (rn_total - r0));
    end
    release_rsp();
    tests_run++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b, required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    int lat, w0, r0, bad_cycles;
    done_on = 1; done_st = 8'h01; res_out = 16'h0777;
    issue(8'h10, 8'h20, 8'h30);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tests_run++;
    if (enable !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: en=%b rdy=%b valid=%b, required 0 1 0", enable, cmd_ready, rsp_valid);
    end
    w0 = wn; r0 = rn_total; bad_cycles = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad_cycles++;
    end
    tests_run++;
    if (wn != w0 || rn_total != r0 || bad_cycles != 0) begin
      tests_failed++;
      $display("FAIL midreset_quiet: writes=%0d reads=%0d rsp_cycles=%0d, required 0 0 0",
               wn - w0, rn_total - r0, bad_cycles);
    end
    issue(8'h44, 8'h55, 8'h66);
    wait_rsp(lat);
    tests_run++;
    if (lat != 7 || rsp_result !== 16'h0777 || rsp_status !== 8'h01 || wlog_data[w0 & 255] !== 8'h44) begin
      tests_failed++;
      $display("FAIL midreset_fresh: lat=%0d res=%h st=%h A=%h, required 7 0777 01 44",
               lat, rsp_result, rsp_status, wlog_data[w0 & 255]);
    end
    release_rsp();
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [DW-1:0] a, b, op;
      logic [RW-1:0] res;
      int lat, w0, r0, hold, exp_reads, exp_lat;
      bit early, is_done;
      logic [RW-1:0] exp_res;
      logic [DW-1:0] exp_st;
      a = DW'($urandom); b = DW'($urandom); op = DW'($urandom); res = RW'($urandom);
      done_on = $urandom_range(0, MAX_POLL + 1);
      done_st = DW'($urandom) | 8'h01;
      nd_st   = DW'($urandom) & 8'hFE;
      res_out = res;
      early   = ($urandom_range(0, 2) == 0);
      hold    = early ? 0 : $urandom_range(0, 3);
      is_done   = (done_on >= 1 && done_on <= MAX_POLL);
      exp_reads = is_done ? done_on : MAX_POLL;
      exp_res   = is_done ? res : '0;
      exp_st    = is_done ? done_st : (nd_st | 8'h80);
      exp_lat   = 3 + WAIT_CYCLES + 2 * exp_reads;
      w0 = wn; r0 = rn_total;
      issue(a, b, op);
      rsp_ready = early;
      wait_rsp(lat);
      tests_run++;
      if (lat != exp_lat || rn_total - r0 != exp_reads || rsp_result !== exp_res || rsp_status !== exp_st) begin
        tests_failed++;
        $display("FAIL rand_rsp[%0d]: lat=%0d reads=%0d res=%h st=%h, required %0d %0d %h %h",
                 it, lat, rn_total - r0, rsp_result, rsp_status, exp_lat, exp_reads, exp_res, exp_st);
      end
      tests_run++;
      if (wn - w0 != 3 || wlog_data[w0 & 255] !== a || wlog_data[(w0 + 1) & 255] !== b ||
          wlog_data[(w0 + 2) & 255] !== op || wlog_addr[(w0 + 2) & 255] !== 2'd2) begin
        tests_failed++;
        $display("FAIL rand_writes[%0d]: n=%0d %h %h %h, required 3 %h %h %h", it, wn - w0,
                 wlog_data[w0 & 255], wlog_data[(w0 + 1) & 255], wlog_data[(w0 + 2) & 255], a, b, op);
      end
      repeat (hold) @(negedge clk);
      release_rsp();
      tests_run++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL rand_release[%0d]: rsp_valid=%b cmd_ready=%b, required 0 1", it, rsp_valid, cmd_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_slow_slave();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    test_random();
    tests_run++;
    if (rn_bad != 0) begin
      tests_failed++;
      $display("FAIL read_addr: %0d status reads at wrong address, required 0", rn_bad);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
